// File: rtl/id_funct_gen_if.sv
// ID/EX ALU-funct stage handshake bundle.
// master = ID side driving the stage, slave = id_funct_gen.
interface id_funct_gen_if #(
  parameter int FUNCT_W = 6,
  parameter int OP_W    = 6
);
  logic               valid_in;
  logic [OP_W-1:0]    op;
  logic [FUNCT_W-1:0] funct_in;
  logic               stall_in;
  logic               flush;
  logic [FUNCT_W-1:0] funct_out;
  logic               valid_out;
  logic               md_busy;
  logic               stall_req;
  logic               md_done;

  modport master (
    output valid_in, op, funct_in, stall_in, flush,
    input  funct_out, valid_out, md_busy, stall_req, md_done
  );

  modport slave (
    input  valid_in, op, funct_in, stall_in, flush,
    output funct_out, valid_out, md_busy, stall_req, md_done
  );
endinterface

// File: rtl/id_funct_gen.sv
// Registered ALU-funct generator for the ID/EX boundary.
// ID_FUNCT_GEN_MD_EN enables the multiply/divide occupancy sequencer.
module id_funct_gen #(
  parameter int FUNCT_W     = 6,
  parameter int OP_W        = 6,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic          clk,
  input  logic          rst,
  id_funct_gen_if.slave io
);
  typedef logic [OP_W-1:0]    op_t;
  typedef logic [FUNCT_W-1:0] fn_t;

  localparam op_t OP_SPECIAL = op_t'(6'h00);
  localparam op_t OP_JAL     = op_t'(6'h03);
  localparam op_t OP_ADDI    = op_t'(6'h08);
  localparam op_t OP_ADDIU   = op_t'(6'h09);
  localparam op_t OP_SLTI    = op_t'(6'h0A);
  localparam op_t OP_SLTIU   = op_t'(6'h0B);
  localparam op_t OP_ANDI    = op_t'(6'h0C);
  localparam op_t OP_ORI     = op_t'(6'h0D);
  localparam op_t OP_XORI    = op_t'(6'h0E);
  localparam op_t OP_LUI     = op_t'(6'h0F);
  localparam op_t OP_LB      = op_t'(6'h20);
  localparam op_t OP_LH      = op_t'(6'h21);
  localparam op_t OP_LW      = op_t'(6'h23);
  localparam op_t OP_LBU     = op_t'(6'h24);
  localparam op_t OP_LHU     = op_t'(6'h25);
  localparam op_t OP_SB      = op_t'(6'h28);
  localparam op_t OP_SH      = op_t'(6'h29);
  localparam op_t OP_SW      = op_t'(6'h2B);

  localparam fn_t F_NOP   = fn_t'(6'h00);
  localparam fn_t F_ADD   = fn_t'(6'h20);
  localparam fn_t F_ADDU  = fn_t'(6'h21);
  localparam fn_t F_AND   = fn_t'(6'h24);
  localparam fn_t F_OR    = fn_t'(6'h25);
  localparam fn_t F_XOR   = fn_t'(6'h26);
  localparam fn_t F_SLT   = fn_t'(6'h2A);
  localparam fn_t F_SLTU  = fn_t'(6'h2B);

  fn_t  dec;
  fn_t  fo_q;
  logic vo_q;
  logic is_ls;

  assign is_ls = io.op == OP_LB || io.op == OP_LH
              || io.op == OP_LW || io.op == OP_LBU
              || io.op == OP_LHU || io.op == OP_SB
              || io.op == OP_SH || io.op == OP_SW;

  // Map primary opcode (or SPECIAL funct) to the ALU funct.
  always_comb begin
    dec = F_NOP;
    unique case (1'b1)
      io.op == OP_SPECIAL: dec = io.funct_in;
      io.op == OP_LUI || io.op == OP_ORI
        || io.op == OP_JAL: dec = F_OR;
      io.op == OP_ADDIU || is_ls: dec = F_ADDU;
      io.op == OP_ADDI:  dec = F_ADD;
      io.op == OP_SLTI:  dec = F_SLT;
      io.op == OP_SLTIU: dec = F_SLTU;
      io.op == OP_ANDI:  dec = F_AND;
      io.op == OP_XORI:  dec = F_XOR;
      default:           dec = F_NOP;
    endcase
  end

  assign io.funct_out = fo_q;
  assign io.valid_out = vo_q;

`ifdef ID_FUNCT_GEN_MD_EN
  localparam int MAX_N =
    MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_N + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t MULT_LD = cnt_t'(MULT_CYCLES - 1);
  localparam cnt_t DIV_LD  = cnt_t'(DIV_CYCLES - 1);
  localparam cnt_t CNT_ONE = cnt_t'(1);

  localparam fn_t F_MULT  = fn_t'(6'h18);
  localparam fn_t F_MULTU = fn_t'(6'h19);
  localparam fn_t F_DIV   = fn_t'(6'h1A);
  localparam fn_t F_DIVU  = fn_t'(6'h1B);

  cnt_t cnt;
  logic busy_q;
  logic done1_q;
  logic is_mult;
  logic is_div;
  logic md_last;
  logic accept;
  cnt_t ld;
  logic ld_busy;
  logic ld_one;

  assign is_mult = io.op == OP_SPECIAL
    && (io.funct_in == F_MULT || io.funct_in == F_MULTU);
  assign is_div = io.op == OP_SPECIAL
    && (io.funct_in == F_DIV || io.funct_in == F_DIVU);
  assign md_last = busy_q && cnt == CNT_ONE;
  // The final busy cycle releases ID so the held instruction
  // is taken exactly once, on the edge ending md_done.
  assign accept = !io.stall_in && (!busy_q || md_last);

  // Occupancy to load for an accepted MD instruction.
  always_comb begin
    ld      = '0;
    ld_busy = 1'b0;
    ld_one  = 1'b0;
    if (io.valid_in && is_mult) begin
      ld      = MULT_LD;
      ld_busy = MULT_CYCLES > 1;
      ld_one  = MULT_CYCLES == 1;
    end else if (io.valid_in && is_div) begin
      ld      = DIV_LD;
      ld_busy = DIV_CYCLES > 1;
      ld_one  = DIV_CYCLES == 1;
    end
  end

  // Stage register plus MD occupancy countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fo_q    <= F_NOP;
      vo_q    <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done1_q <= 1'b0;
    end else if (io.flush) begin
      fo_q    <= F_NOP;
      vo_q    <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done1_q <= 1'b0;
    end else if (accept) begin
      fo_q    <= io.valid_in ? dec : F_NOP;
      vo_q    <= io.valid_in;
      cnt     <= ld;
      busy_q  <= ld_busy;
      done1_q <= ld_one;
    end else begin
      done1_q <= 1'b0;
      if (busy_q) begin
        if (cnt != '0) cnt <= cnt - CNT_ONE;
        busy_q <= cnt > CNT_ONE;
      end
    end
  end

  assign io.md_busy   = busy_q;
  assign io.md_done   = md_last || done1_q;
  assign io.stall_req = io.stall_in || (busy_q && !md_last);
`else
  // Stage register; MD functs pass through like any SPECIAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fo_q <= F_NOP;
      vo_q <= 1'b0;
    end else if (io.flush) begin
      fo_q <= F_NOP;
      vo_q <= 1'b0;
    end else if (!io.stall_in) begin
      fo_q <= io.valid_in ? dec : F_NOP;
      vo_q <= io.valid_in;
    end
  end

  assign io.md_busy   = 1'b0;
  assign io.md_done   = 1'b0;
  assign io.stall_req = io.stall_in;
`endif
endmodule

// File: tb/tb_id_funct_gen.sv
// Self-checking bench for id_funct_gen.
// Vector table, directed sequences and a random model run.
module tb_id_funct_gen;
`ifdef ID_FUNCT_GEN_MD_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_funct_gen_if #(.FUNCT_W(6), .OP_W(6)) bus ();
  id_funct_gen_if #(.FUNCT_W(6), .OP_W(6)) bus1 ();

  id_funct_gen #(
    .FUNCT_W(6), .OP_W(6),
    .MULT_CYCLES(4), .DIV_CYCLES(32)
  ) dut (
    .clk(clk), .rst(rst), .io(bus)
  );

  id_funct_gen #(
    .FUNCT_W(6), .OP_W(6),
    .MULT_CYCLES(1), .DIV_CYCLES(2)
  ) dut1 (
    .clk(clk), .rst(rst), .io(bus1)
  );

  assign bus1.valid_in = bus.valid_in;
  assign bus1.op       = bus.op;
  assign bus1.funct_in = bus.funct_in;
  assign bus1.stall_in = bus.stall_in;
  assign bus1.flush    = bus.flush;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic       v;
    logic [5:0] op;
    logic [5:0] fn;
    logic [5:0] ef;
    logic       ev;
  } vec_t;

  vec_t vt[12];
  logic [5:0] alu_of [logic [5:0]];
  logic [5:0] pool[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] o,
                       input logic [5:0] f, input logic s,
                       input logic fl);
    bus.valid_in = v;
    bus.op       = o;
    bus.funct_in = f;
    bus.stall_in = s;
    bus.flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  function automatic logic [5:0] ref_dec(input logic [5:0] o,
                                         input logic [5:0] f);
    if (o == 6'h00) return f;
    if (alu_of.exists(o)) return alu_of[o];
    return 6'h00;
  endfunction

  logic [5:0] exp_f;
  logic       exp_v;

  initial begin
    alu_of[6'h0F] = 6'h25; alu_of[6'h0D] = 6'h25;
    alu_of[6'h03] = 6'h25; alu_of[6'h09] = 6'h21;
    alu_of[6'h20] = 6'h21; alu_of[6'h21] = 6'h21;
    alu_of[6'h23] = 6'h21; alu_of[6'h24] = 6'h21;
    alu_of[6'h25] = 6'h21; alu_of[6'h28] = 6'h21;
    alu_of[6'h29] = 6'h21; alu_of[6'h2B] = 6'h21;
    alu_of[6'h08] = 6'h20; alu_of[6'h0A] = 6'h2A;
    alu_of[6'h0B] = 6'h2B; alu_of[6'h0C] = 6'h24;
    alu_of[6'h0E] = 6'h26;
    pool = '{6'h00, 6'h00, 6'h03, 6'h08, 6'h09, 6'h0A,
             6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20,
             6'h23, 6'h25, 6'h28, 6'h2B, 6'h02, 6'h3F};

    vt[0]  = '{1'b1, 6'h0F, 6'h00, 6'h25, 1'b1};
    vt[1]  = '{1'b1, 6'h2B, 6'h00, 6'h21, 1'b1};
    vt[2]  = '{1'b1, 6'h3F, 6'h00, 6'h00, 1'b1};
    vt[3]  = '{1'b1, 6'h00, 6'h2A, 6'h2A, 1'b1};
    vt[4]  = '{1'b0, 6'h0F, 6'h00, 6'h00, 1'b0};
    vt[5]  = '{1'b1, 6'h08, 6'h11, 6'h20, 1'b1};
    vt[6]  = '{1'b1, 6'h0A, 6'h00, 6'h2A, 1'b1};
    vt[7]  = '{1'b1, 6'h0B, 6'h00, 6'h2B, 1'b1};
    vt[8]  = '{1'b1, 6'h0C, 6'h00, 6'h24, 1'b1};
    vt[9]  = '{1'b1, 6'h0E, 6'h00, 6'h26, 1'b1};
    vt[10] = '{1'b1, 6'h03, 6'h00, 6'h25, 1'b1};
    vt[11] = '{1'b1, 6'h24, 6'h07, 6'h21, 1'b1};

    // Reset state, stall_req follows stall_in
    drive(1'b1, 6'h0F, 6'h00, 1'b1, 1'b0);
    #1;
    chk("rst_stall_req_hi", bus.stall_req, 1);
    tick();
    tick();
    chk("rst_funct", bus.funct_out, 6'h00);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_busy", bus.md_busy, 0);
    chk("rst_done", bus.md_done, 0);
    drive(1'b1, 6'h0F, 6'h00, 1'b0, 1'b0);
    #1;
    chk("rst_stall_req_lo", bus.stall_req, 0);
    rst = 1'b0;
    tick();

    // Vector table, one-cycle latency
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].v, vt[i].op, vt[i].fn, 1'b0, 1'b0);
      tick();
      chk($sformatf("vec%0d_funct", i), bus.funct_out, vt[i].ef);
      chk($sformatf("vec%0d_valid", i), bus.valid_out, vt[i].ev);
    end

    // Stall holds the register for 3 cycles
    drive(1'b1, 6'h0D, 6'h00, 1'b0, 1'b0);
    tick();
    chk("pre_stall_funct", bus.funct_out, 6'h25);
    drive(1'b1, 6'h09, 6'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_req", i), bus.stall_req, 1);
      tick();
      chk($sformatf("stall%0d_funct", i), bus.funct_out, 6'h25);
    end
    drive(1'b1, 6'h09, 6'h00, 1'b0, 1'b0);
    tick();
    chk("unstall_funct", bus.funct_out, 6'h21);
    chk("unstall_valid", bus.valid_out, 1);

    // Flush discards input and clears stage
    drive(1'b1, 6'h08, 6'h00, 1'b0, 1'b1);
    tick();
    chk("flush_funct", bus.funct_out, 6'h00);
    chk("flush_valid", bus.valid_out, 0);
    drive(1'b1, 6'h0E, 6'h00, 1'b1, 1'b1);
    tick();
    chk("flush_stall_valid", bus.valid_out, 0);

    // Async reset without a clock edge
    drive(1'b1, 6'h0E, 6'h00, 1'b0, 1'b0);
    tick();
    chk("pre_arst_funct", bus.funct_out, 6'h26);
    #1 rst = 1'b1;
    #1;
    chk("arst_funct", bus.funct_out, 6'h00);
    chk("arst_valid", bus.valid_out, 0);
    rst = 1'b0;
    tick();

    // DIV through the default-latency instance
    drive(1'b1, 6'h00, 6'h1A, 1'b0, 1'b0);
    tick();
    chk("div_funct", bus.funct_out, 6'h1A);
    chk("div_busy", bus.md_busy, MD);
    chk("div_stall_req", bus.stall_req, MD);
    rst_pulse();

    // Back-to-back MULTU on the single-cycle instance
    drive(1'b1, 6'h00, 6'h19, 1'b0, 1'b0);
    tick();
    chk("m1a_funct", bus1.funct_out, 6'h19);
    chk("m1a_busy", bus1.md_busy, 0);
    chk("m1a_done", bus1.md_done, MD);
    tick();
    chk("m1b_funct", bus1.funct_out, 6'h19);
    chk("m1b_valid", bus1.valid_out, 1);
    chk("m1b_busy", bus1.md_busy, 0);
    chk("m1b_done", bus1.md_done, MD);
    drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
    tick();
    chk("m1c_done", bus1.md_done, 0);
    rst_pulse();

    if (MD) begin
      // MULT occupancy with N=4
      drive(1'b1, 6'h00, 6'h18, 1'b0, 1'b0);
      tick();
      chk("mul_c1_valid", bus.valid_out, 1);
      chk("mul_c1_funct", bus.funct_out, 6'h18);
      chk("mul_c1_busy", bus.md_busy, 1);
      chk("mul_c1_done", bus.md_done, 0);
      drive(1'b1, 6'h0D, 6'h00, 1'b0, 1'b0);
      #1;
      chk("mul_c1_req", bus.stall_req, 1);
      tick();
      chk("mul_c2_funct", bus.funct_out, 6'h18);
      chk("mul_c2_busy", bus.md_busy, 1);
      chk("mul_c2_done", bus.md_done, 0);
      tick();
      chk("mul_c3_busy", bus.md_busy, 1);
      chk("mul_c3_done", bus.md_done, 1);
      tick();
      chk("mul_c4_funct", bus.funct_out, 6'h25);
      chk("mul_c4_busy", bus.md_busy, 0);
      chk("mul_c4_done", bus.md_done, 0);

      // Back-to-back MULTU, no bubble
      drive(1'b1, 6'h00, 6'h19, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      chk("b2b_first_done", bus.md_done, 1);
      tick();
      chk("b2b_second_busy", bus.md_busy, 1);
      chk("b2b_second_done", bus.md_done, 0);
      chk("b2b_second_funct", bus.funct_out, 6'h19);
      rst_pulse();
      chk("arst_busy", bus.md_busy, 0);

      // DIV flushed in occupancy cycle 10
      drive(1'b1, 6'h00, 6'h1A, 1'b0, 1'b0);
      tick();
      drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
      for (int c = 2; c <= 10; c++) begin
        tick();
        chk($sformatf("dv_c%0d_busy", c), bus.md_busy, 1);
        chk($sformatf("dv_c%0d_done", c), bus.md_done, 0);
      end
      drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b1);
      tick();
      chk("dvf_busy", bus.md_busy, 0);
      chk("dvf_valid", bus.valid_out, 0);
      chk("dvf_funct", bus.funct_out, 6'h00);
      chk("dvf_done", bus.md_done, 0);
      drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
      for (int c = 0; c < 24; c++) begin
        tick();
        chk("dvf_no_done", bus.md_done, 0);
      end
    end

    // Random run against the reference model
    rst_pulse();
    exp_f = 6'h00;
    exp_v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic v, s, fl;
      logic [5:0] o, f;
      v  = $urandom_range(0, 3) != 0;
      s  = $urandom_range(0, 3) == 0;
      fl = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 4) == 0) o = 6'($urandom);
      else o = pool[$urandom_range(0, pool.size() - 1)];
      f = 6'($urandom);
      if (MD && o == 6'h00 && f >= 6'h18 && f <= 6'h1B)
        f = 6'h20;
      drive(v, o, f, s, fl);
      #1;
      chk("rnd_stall_req", bus.stall_req, s);
      if (fl) begin
        exp_f = 6'h00;
        exp_v = 1'b0;
      end else if (!s) begin
        exp_f = v ? ref_dec(o, f) : 6'h00;
        exp_v = v;
      end
      tick();
      chk("rnd_funct", bus.funct_out, exp_f);
      chk("rnd_valid", bus.valid_out, exp_v);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
